// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-requester SDRAM arbiter.
package sdram_arb_pkg;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  typedef enum logic {OWN_VID = 1'b0, OWN_CPU = 1'b1} owner_t;
endpackage

// File: rtl/sdram_arb_pick.sv
// Owner selection and next starvation-counter value, evaluated while IDLE.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic             vid_req_i,
  input  logic             cpu_req_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             any_o,
  output owner_t           pick_o,
  output logic [CNT_W-1:0] cnt_d_o
);
  always_comb begin
    any_o   = vid_req_i | cpu_req_i;
    pick_o  = OWN_VID;
    cnt_d_o = cnt_i;
    // Video wins ties unless the CPU has been passed over STARVE_LIMIT times.
    if (cpu_req_i && (!vid_req_i || cnt_i == CNT_W'(STARVE_LIMIT)))
      pick_o = OWN_CPU;
    if (!cpu_req_i || pick_o == OWN_CPU)
      cnt_d_o = '0;
    else if (cnt_i != CNT_MAX)
      cnt_d_o = cnt_i + 1'b1;
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Video/CPU arbiter in front of a single SDRAM controller port; IDLE->GRANT->ACK.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                vid_req_i,
  input  logic [ADDR_W-1:0]   vid_addr_i,
  output logic                vid_ack_o,
  output logic [DATA_W-1:0]   vid_rdata_o,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  input  logic [DATA_W/8-1:0] cpu_wmask_i,
  output logic                cpu_ack_o,
  output logic [DATA_W-1:0]   cpu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o,
  output logic                owner_o,
  output logic                err_o
);
  state_t              state_q, state_d;
  owner_t              owner_q, owner_d, pick;
  logic [CNT_W-1:0]    cnt_q, cnt_d, pick_cnt;
  logic                any_req;
  logic                we_q, we_d, req_q, req_d, busy_q, busy_d, err_q, err_d;
  logic                vack_q, vack_d, cack_q, cack_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, vrd_q, vrd_d, crd_q, crd_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;

  sdram_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .vid_req_i (vid_req_i),
    .cpu_req_i (cpu_req_i),
    .cnt_i     (cnt_q),
    .any_o     (any_req),
    .pick_o    (pick),
    .cnt_d_o   (pick_cnt)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    vrd_d   = vrd_q;
    crd_d   = crd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = pick_cnt;
        if (mem_ack_i) err_d = 1'b1;
        if (any_req) begin
          state_d = GRANT;
          owner_d = pick;
          if (pick == OWN_CPU) begin
            we_d    = cpu_we_i;
            addr_d  = cpu_addr_i;
            wdata_d = cpu_wdata_i;
            wmask_d = cpu_wmask_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = vid_addr_i;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      GRANT: begin
        if (mem_ack_i) begin
          state_d = ACK;
          if (owner_q == OWN_CPU) crd_d = mem_rdata_i;
          else                    vrd_d = mem_rdata_i;
        end
      end
      ACK: begin
        // No arbitration here: a requester dropping req on ack must not be re-granted.
        state_d = IDLE;
        if (mem_ack_i) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == GRANT);
    busy_d = (state_d != IDLE);
    vack_d = (state_d == ACK) && (owner_d == OWN_VID);
    cack_d = (state_d == ACK) && (owner_d == OWN_CPU);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= OWN_VID;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      vrd_q   <= '0;
      crd_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      vack_q  <= 1'b0;
      cack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      vrd_q   <= vrd_d;
      crd_q   <= crd_d;
      err_q   <= err_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      vack_q  <= vack_d;
      cack_q  <= cack_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;
  assign vid_ack_o   = vack_q;
  assign cpu_ack_o   = cack_q;
  assign vid_rdata_o = vrd_q;
  assign cpu_rdata_o = crd_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;
  assign err_o       = err_q;
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, max consecutive video grants while the CPU waits (range 1..15).
REQ-004 SHALL have port clk  in  1  single system clock; all logic rises on clk.
REQ-005 SHALL have port reset_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports vid_req_i in 1, vid_addr_i in ADDR_W, vid_ack_o out 1, vid_rdata_o out DATA_W: video read-only requester.
REQ-007 SHALL have ports cpu_req_i in 1, cpu_we_i in 1, cpu_addr_i in ADDR_W, cpu_wdata_i in DATA_W, cpu_wmask_i in DATA_W/8, cpu_ack_o out 1, cpu_rdata_o out DATA_W: CPU requester.
REQ-008 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out ADDR_W, mem_wdata_o out DATA_W, mem_wmask_o out DATA_W/8, mem_ack_i in 1, mem_rdata_i in DATA_W: SDRAM controller port.
REQ-009 SHALL have ports busy_o out 1 (state not IDLE), owner_o out 1 (0=video, 1=CPU, last grant), err_o out 1 (sticky spurious-ack flag).

Function
REQ-010 SHALL implement FSM IDLE -> GRANT -> ACK -> IDLE; all outputs registered.
REQ-011 In IDLE with any req high, SHALL select an owner, latch that owner's command fields, and enter GRANT next cycle.
REQ-012 Selection SHALL give video priority, except the CPU SHALL win when cpu_req_i=1 and starve_cnt = STARVE_LIMIT.
REQ-013 starve_cnt SHALL increment (saturating at 15) on each video grant made while cpu_req_i=1, and clear on a CPU grant or whenever cpu_req_i=0 in IDLE.
REQ-014 In GRANT, mem_req_o SHALL be 1 with the latched command stable; video grants drive mem_we_o=0 and mem_wmask_o=0.
REQ-015 On mem_ack_i=1 in GRANT, the next cycle SHALL be ACK, with mem_req_o=0, the owner's ack_o=1 for exactly one cycle, and the owner's rdata_o = sampled mem_rdata_i.
REQ-016 rdata_o SHALL hold its value until the next ack to that requester; the other requester's rdata_o SHALL be unchanged.
REQ-017 ACK SHALL perform no arbitration, so a requester that drops req on seeing ack is never re-granted a stale request.
REQ-018 Minimum latency: req sampled at cycle N, mem_req_o at N+1, ack_o at N+2 if mem_ack_i at N+1; peak throughput one transfer per 3 cycles.
REQ-019 Requester inputs SHALL be ignored while not IDLE; a req that drops before being sampled in IDLE is lost without error.
REQ-020 mem_ack_i=1 in IDLE or ACK SHALL set err_o; err_o clears only on reset.
REQ-021 Simultaneous vid_req_i and cpu_req_i in IDLE SHALL resolve by REQ-012 in the same cycle; the loser stays pending.

Reset
REQ-022 On reset_i=1 at a clk edge, the FSM SHALL enter IDLE and the following SHALL clear: mem_req_o, mem_we_o, both ack_o, busy_o, err_o, starve_cnt, owner_o; addresses, data, masks, and rdata_o SHALL be 0.
REQ-023 Reset during GRANT SHALL abandon the transfer without issuing any ack_o; the SDRAM controller shares reset_i.

Structure
REQ-024 Package sdram_arb_pkg SHALL hold the state enum (IDLE, GRANT, ACK), the owner enum (OWN_VID, OWN_CPU), and the counter width constant.
REQ-025 A sub-module sdram_arb_pick SHALL implement the combinational selection (REQ-012) and next-counter logic (REQ-013).

Verification
REQ-026 Scenario: CPU read only, mem_ack_i one cycle after mem_req_o, mem_rdata_i=0xDEADBEEF -> cpu_ack_o pulses at N+2, cpu_rdata_o=0xDEADBEEF, vid_ack_o stays 0.
REQ-027 Scenario: both requesters request in the same cycle -> video is granted first, owner_o=0; the CPU is served on the next arbitration.
REQ-028 Scenario: video requests continuously, CPU requests continuously, STARVE_LIMIT=8 -> exactly 8 video grants, then 1 CPU grant; the pattern repeats.
REQ-029 Scenario: CPU write with wmask 0b0101 and addr 0x123456 -> mem_we_o=1, mem_wmask_o=0101, mem_addr_o=0x123456 held stable until mem_ack_i.
REQ-030 Scenario: reset_i asserted in GRANT with mem_ack_i withheld -> next cycle mem_req_o=0, busy_o=0, and no ack_o fires.
REQ-031 Scenario: mem_ack_i pulsed while IDLE -> err_o=1 and remains 1 until reset.
